// File: rtl/sync_bank.sv
// sync_bank: bank of multi-flop synchronizers with edge pulses, plus a gray-coded pointer channel.
// Define SYNC_BANK_FILTER_EN to compile in the per-channel level stability filter.
module sync_bank #(
    parameter int CHANNELS      = 4,
    parameter int STAGES        = 2,
    parameter int FILTER_CYCLES = 3,
    parameter int GRAY_WIDTH    = 5
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [CHANNELS-1:0]   async_in,
    output logic [CHANNELS-1:0]   level_out,
    output logic [CHANNELS-1:0]   rise_pulse,
    output logic [CHANNELS-1:0]   fall_pulse,
    input  logic [GRAY_WIDTH-1:0] gray_in,
    output logic [GRAY_WIDTH-1:0] gray_out,
    output logic [GRAY_WIDTH-1:0] bin_out,
    output logic                  ptr_changed
);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("sync_bank: STAGES must be at least 2");
        end
        if (GRAY_WIDTH < 2) begin : g_bad_gray
            $error("sync_bank: GRAY_WIDTH must be at least 2");
        end
        if (FILTER_CYCLES < 0) begin : g_bad_filter
            $error("sync_bank: FILTER_CYCLES must not be negative");
        end
    endgenerate

    function automatic logic [GRAY_WIDTH-1:0] gray2bin(input logic [GRAY_WIDTH-1:0] g);
        logic [GRAY_WIDTH-1:0] b;
        b[GRAY_WIDTH-1] = g[GRAY_WIDTH-1];
        for (int i = GRAY_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [CHANNELS-1:0]   lvl_sync_p  [STAGES];
    logic [GRAY_WIDTH-1:0] gray_sync_p [STAGES];
    logic [CHANNELS-1:0]   sync_last;
    logic [CHANNELS-1:0]   level;
    logic [CHANNELS-1:0]   level_d;
    logic [GRAY_WIDTH-1:0] bin_q;
    logic [GRAY_WIDTH-1:0] bin_d;

    // Synchronizer chains: stage 0 samples the asynchronous inputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < STAGES; s++) begin
                lvl_sync_p[s]  <= '0;
                gray_sync_p[s] <= '0;
            end
        end else begin
            lvl_sync_p[0]  <= async_in;
            gray_sync_p[0] <= gray_in;
            for (int s = 1; s < STAGES; s++) begin
                lvl_sync_p[s]  <= lvl_sync_p[s-1];
                gray_sync_p[s] <= gray_sync_p[s-1];
            end
        end
    end

    assign sync_last = lvl_sync_p[STAGES-1];

    // Level stage: optional stability filter between the sync chain and level_out
`ifdef SYNC_BANK_FILTER_EN
    generate
        if (FILTER_CYCLES > 0) begin : g_filter
            localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

            logic [CNT_W-1:0]    stable_cnt [CHANNELS];
            logic [CHANNELS-1:0] level_q;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    level_q <= '0;
                    for (int c = 0; c < CHANNELS; c++) begin
                        stable_cnt[c] <= '0;
                    end
                end else begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (sync_last[c] != level_q[c]) begin
                            // The FILTER_CYCLES-th consecutive disagreement commits the new level
                            if (stable_cnt[c] == CNT_LAST) begin
                                level_q[c]    <= sync_last[c];
                                stable_cnt[c] <= '0;
                            end else begin
                                stable_cnt[c] <= stable_cnt[c] + 1'b1;
                            end
                        end else begin
                            stable_cnt[c] <= '0;
                        end
                    end
                end
            end

            assign level = level_q;
        end else begin : g_no_filter
            assign level = sync_last;
        end
    endgenerate
`else
    assign level = sync_last;
`endif

    // Edge and pointer stage: delayed copies for pulse decode, registered gray-to-binary
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            level_d <= '0;
            bin_q   <= '0;
            bin_d   <= '0;
        end else begin
            level_d <= level;
            bin_q   <= gray2bin(gray_sync_p[STAGES-1]);
            bin_d   <= bin_q;
        end
    end

    assign level_out   = level;
    assign rise_pulse  = level & ~level_d;
    assign fall_pulse  = ~level & level_d;
    assign gray_out    = gray_sync_p[STAGES-1];
    assign bin_out     = bin_q;
    assign ptr_changed = (bin_q != bin_d);

endmodule

// File: tb/tb_sync_bank.sv
// Scoreboard bench for sync_bank: stimulus pushes expected outputs, a monitor pops and compares each cycle.
module tb_sync_bank;

    localparam int CH = 4;
    localparam int ST = 2;
    localparam int FC = 3;
    localparam int GW = 4;
`ifdef SYNC_BANK_FILTER_EN
    localparam int FILT = FC;
`else
    localparam int FILT = 0;
`endif

    logic          clk;
    logic          resetn;
    logic [CH-1:0] async_in;
    logic [CH-1:0] level_out;
    logic [CH-1:0] rise_pulse;
    logic [CH-1:0] fall_pulse;
    logic [GW-1:0] gray_in;
    logic [GW-1:0] gray_out;
    logic [GW-1:0] bin_out;
    logic          ptr_changed;

    sync_bank #(
        .CHANNELS(CH),
        .STAGES(ST),
        .FILTER_CYCLES(FC),
        .GRAY_WIDTH(GW)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .async_in(async_in),
        .level_out(level_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .gray_in(gray_in),
        .gray_out(gray_out),
        .bin_out(bin_out),
        .ptr_changed(ptr_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [CH-1:0] lvl;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
        logic [GW-1:0] gout;
        logic [GW-1:0] bin;
        logic          ptr;
    } exp_t;

    exp_t          exp_q[$];
    logic [CH-1:0] in_q[$];   // in_q[k] = async_in present at edge k+1 since reset release
    logic [GW-1:0] g_q[$];
    logic [CH-1:0] lvl_q[$];  // lvl_q[n] = expected level_out after edge n (index 0 = reset)
    logic [GW-1:0] bin_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Value of the last synchronizer stage after edge m
    function automatic logic [CH-1:0] syn_in(input int m);
        return (m >= ST) ? in_q[m-ST] : '0;
    endfunction

    function automatic logic [GW-1:0] syn_g(input int m);
        return (m >= ST) ? g_q[m-ST] : '0;
    endfunction

    function automatic logic [GW-1:0] g2b(input logic [GW-1:0] g);
        logic [GW-1:0] b;
        b = g;
        for (int k = 1; k < GW; k++) b = b ^ (g >> k);
        return b;
    endfunction

    task automatic model_step();
        exp_t          e;
        int            n;
        logic [CH-1:0] prev, cur, s;
        logic          ok;
        if (!resetn) begin
            in_q.delete();
            g_q.delete();
            lvl_q.delete();
            bin_q.delete();
            lvl_q.push_back('0);
            bin_q.push_back('0);
            e.lvl = '0; e.rise = '0; e.fall = '0; e.gout = '0; e.bin = '0; e.ptr = 1'b0;
        end else begin
            in_q.push_back(async_in);
            g_q.push_back(gray_in);
            n    = in_q.size();
            prev = lvl_q[n-1];
            if (FILT == 0) begin
                cur = syn_in(n);
            end else begin
                cur = prev;
                // A channel flips only when the synced value opposed it for the last FILT samples
                for (int c = 0; c < CH; c++) begin
                    if (n >= FILT) begin
                        ok = 1'b1;
                        for (int j = 1; j <= FILT; j++) begin
                            s = syn_in(n - j);
                            if (s[c] == prev[c]) ok = 1'b0;
                        end
                        if (ok) cur[c] = ~prev[c];
                    end
                end
            end
            lvl_q.push_back(cur);
            bin_q.push_back(g2b(syn_g(n - 1)));
            e.lvl  = cur;
            e.rise = cur & ~prev;
            e.fall = ~cur & prev;
            e.gout = syn_g(n);
            e.bin  = bin_q[n];
            e.ptr  = (bin_q[n] != bin_q[n-1]);
        end
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs at the falling edge and record what the next rising edge must produce
    task automatic cycle(input logic rn, input logic [CH-1:0] a, input logic [GW-1:0] g);
        @(negedge clk);
        resetn   = rn;
        async_in = a;
        gray_in  = g;
        model_step();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_reset_level", 32'(level_out), 32'd0);
        chk("async_reset_rise", 32'(rise_pulse), 32'd0);
        chk("async_reset_fall", 32'(fall_pulse), 32'd0);
        chk("async_reset_gray", 32'(gray_out), 32'd0);
        chk("async_reset_bin", 32'(bin_out), 32'd0);
        chk("async_reset_ptr", 32'(ptr_changed), 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("level_out", 32'(level_out), 32'(e.lvl));
                chk("rise_pulse", 32'(rise_pulse), 32'(e.rise));
                chk("fall_pulse", 32'(fall_pulse), 32'(e.fall));
                chk("gray_out", 32'(gray_out), 32'(e.gout));
                chk("bin_out", 32'(bin_out), 32'(e.bin));
                chk("ptr_changed", 32'(ptr_changed), 32'(e.ptr));
            end
        end
    end

    task automatic random_phase(input int segs);
        logic [CH-1:0] a;
        int            p;
        logic [GW-1:0] pg;
        p = 0;
        for (int i = 0; i < segs; i++) begin
            a  = CH'($urandom);
            p  = (p + int'($urandom_range(0, 1))) % (1 << GW);
            pg = GW'(p ^ (p >> 1));
            repeat ($urandom_range(1, 6)) cycle(1'b1, a, pg);
        end
    endtask

    initial begin : stimulus
        logic [GW-1:0] gseq [4];
        resetn   = 1'b0;
        async_in = '0;
        gray_in  = '0;
        repeat (3) cycle(1'b0, '0, '0);

        // Single-edge rise on channels 0 and 2
        cycle(1'b1, 4'b0000, '0);
        repeat (6) cycle(1'b1, 4'b0101, '0);

        // Simultaneous rise on ch1 and fall on ch2
        repeat (6) cycle(1'b1, 4'b0100, '0);
        repeat (6) cycle(1'b1, 4'b0010, '0);

        // Short glitch on ch0, then a long pulse
        repeat (6) cycle(1'b1, 4'b0000, '0);
        repeat (2) cycle(1'b1, 4'b0001, '0);
        repeat (6) cycle(1'b1, 4'b0000, '0);
        repeat (6) cycle(1'b1, 4'b0001, '0);
        repeat (6) cycle(1'b1, 4'b0000, '0);

        // Gray pointer steps 0..3
        gseq[0] = 4'b0000; gseq[1] = 4'b0001; gseq[2] = 4'b0011; gseq[3] = 4'b0010;
        for (int i = 0; i < 4; i++) repeat (4) cycle(1'b1, '0, gseq[i]);

        // Wrap from all-ones to zero
        repeat (5) cycle(1'b1, '0, 4'b1000);
        repeat (5) cycle(1'b1, '0, 4'b0000);

        random_phase(40);

        // Asynchronous reset with inputs held nonzero across assertion and release
        repeat (10) cycle(1'b1, 4'b1011, 4'b0110);
        do_reset();
        repeat (3) cycle(1'b0, 4'b1011, 4'b0110);
        repeat (10) cycle(1'b1, 4'b1011, 4'b0110);

        random_phase(40);
        repeat (8) cycle(1'b1, '0, '0);

        @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_bank.md
SYNC_BANK -- requirements
Module: sync_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent single-bit asynchronous inputs.
REQ-002 SHALL have parameter STAGES, default 2: flip-flop stages per synchronizer; values below 2 are an elaboration error.
REQ-003 SHALL have parameter FILTER_CYCLES, default 3: required stability period of the level filter; 0 bypasses the filter.
REQ-004 SHALL have parameter GRAY_WIDTH, default 5: width of the gray-coded pointer channel; values below 2 are an elaboration error.
REQ-005 SHALL have port clk  input  1  sole clock; all state is clocked on its rising edge.
REQ-006 SHALL have port resetn  input  1  asynchronous reset, active-low.
REQ-007 SHALL have port async_in  input  CHANNELS  asynchronous level inputs.
REQ-008 SHALL have port level_out  output  CHANNELS  synchronized and, when the filter is built in, filtered levels.
REQ-009 SHALL have port rise_pulse  output  CHANNELS  one-cycle pulse on each 0->1 of level_out.
REQ-010 SHALL have port fall_pulse  output  CHANNELS  one-cycle pulse on each 1->0 of level_out.
REQ-011 SHALL have port gray_in  input  GRAY_WIDTH  asynchronous gray-coded pointer.
REQ-012 SHALL have port gray_out  output  GRAY_WIDTH  synchronized gray pointer.
REQ-013 SHALL have port bin_out  output  GRAY_WIDTH  registered binary equivalent of gray_out.
REQ-014 SHALL have port ptr_changed  output  1  one-cycle pulse when bin_out changes value.

Function
REQ-015 Each async_in bit SHALL pass through its own STAGES-deep flip-flop chain; no combinational path from any async input to any output.
REQ-016 Without filter: level_out SHALL equal the last sync stage; an input stable before edge 1 appears on level_out after edge STAGES.
REQ-017 rise_pulse/fall_pulse SHALL be decoded from level_out and a one-cycle delayed copy; the pulse is high exactly in the first cycle level_out holds its new value.
REQ-018 Simultaneous transitions on different channels SHALL produce their pulses in the same cycle, independently.
REQ-019 gray_in SHALL pass through a STAGES-deep chain per bit; gray_out equals the last stage.
REQ-020 bin_out SHALL be gray_out converted (bin[MSB]=gray[MSB], bin[i]=bin[i+1] xor gray[i]) and registered: one edge after gray_out.
REQ-021 ptr_changed SHALL be high for exactly the first cycle of each new bin_out value, including wrap-around from all-ones to zero.
REQ-022 The gray path SHALL never be filtered.

Reset
REQ-023 resetn low SHALL clear all sync stages, filter counters, delayed copies and outputs to 0 immediately, with no clock edge required.
REQ-024 No rise_pulse, fall_pulse or ptr_changed SHALL be produced by reset assertion or release; an input already high at release produces rise_pulse normally once synchronized.
REQ-025 Reset deassertion is synchronous to clk, guaranteed by the upstream reset synchronizer.

Configuration
REQ-026 Macro SYNC_BANK_FILTER_EN SHALL compile in a per-channel counter of width clog2(FILTER_CYCLES+1).
REQ-027 With SYNC_BANK_FILTER_EN and FILTER_CYCLES>0: the counter increments each cycle the last sync stage differs from level_out and clears whenever they agree; level_out loads the synced value when the difference has persisted FILTER_CYCLES consecutive cycles (update after edge STAGES+FILTER_CYCLES); the counter then clears.
REQ-028 Without SYNC_BANK_FILTER_EN, or with FILTER_CYCLES=0, no counter SHALL exist and REQ-016 timing applies.

Verification
REQ-029 Reset: drive nonzero inputs for 10 cycles, assert resetn between edges -> all outputs 0 before next edge; release -> no pulses except rise_pulse after synchronization for inputs held high.
REQ-030 No filter, STAGES=2: async_in 0000->0101 before edge 1 -> level_out 0101 after edge 2, rise_pulse 0101 one cycle, fall_pulse 0000.
REQ-031 Filter, STAGES=2, FILTER_CYCLES=3: async_in[0] high 2 cycles -> level_out[0] stays 0, no pulses; high 6 cycles -> level_out[0]=1 after edge 5, one rise_pulse.
REQ-032 Simultaneous: ch1 0->1 and ch2 1->0 same edge -> rise_pulse 0010 and fall_pulse 0100 in same cycle.
REQ-033 Gray, GRAY_WIDTH=4, STAGES=2: gray_in 0000,0001,0011,0010 each held 4 cycles -> bin_out 0,1,2,3, each 3 edges after change, one ptr_changed per step.
REQ-034 Wrap: gray_in 1000->0000 -> bin_out 1111->0000, exactly one ptr_changed pulse.
